// File: rtl/dm_dmi_regfile.sv
// Debug-module DMI register front-end: decodes DMI requests, holds the DM register set and
// drives hart control and the abstract-command handshake. Define DM_PROGBUF_EN to build progbuf storage.
module dm_dmi_regfile #(
    parameter int DATA_COUNT   = 2,
    parameter int PROGBUF_SIZE = 2
) (
    input  logic        clk2,
    input  logic        rst_ck2,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_op,
    output logic        resp_vld,
    input  logic        resp_rdy,
    output logic [6:0]  resp_addr,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_op,
    output logic        haltreq,
    output logic        resumereq,
    output logic        ndmreset,
    output logic        dmactive,
    input  logic        hart_halted,
    input  logic        hart_resumeack,
    output logic        cmd_vld,
    input  logic        cmd_rdy,
    output logic [31:0] cmd_word,
    input  logic        cmd_done,
    input  logic [2:0]  cmd_err,
    input  logic        hart_data_we,
    input  logic [3:0]  hart_data_idx,
    input  logic [31:0] hart_data_wdata,
    output logic [2:0]  dbg_state
);
    // Handshakes: a transfer happens on a rising clk2 edge where valid and ready are both high.
    typedef enum logic { D_IDLE, D_RESP } dmi_state_e;
    typedef enum logic [1:0] { C_IDLE, C_ISSUE, C_BUSY } cmd_state_e;

    localparam logic [6:0] A_DMCONTROL = 7'h10;
    localparam logic [6:0] A_DMSTATUS  = 7'h11;
    localparam logic [6:0] A_ABSCS     = 7'h16;
    localparam logic [6:0] A_COMMAND   = 7'h17;
`ifdef DM_PROGBUF_EN
    localparam logic PB_EN = 1'b1;
`else
    localparam logic PB_EN = 1'b0;
`endif
    localparam logic [4:0] PB_FIELD = 5'(PROGBUF_SIZE) & {5{PB_EN}};

    dmi_state_e  dmi_state_q, dmi_state_d;
    cmd_state_e  cmd_state_q, cmd_state_d;
    logic [6:0]  resp_addr_q, resp_addr_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [1:0]  resp_op_q, resp_op_d;
    logic        haltreq_q, haltreq_d, resumereq_q, resumereq_d;
    logic        ndmreset_q, ndmreset_d, dmactive_q, dmactive_d;
    logic        resumeack_q, resumeack_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic [31:0] cmd_word_q, cmd_word_d;
    logic [31:0] data_q [DATA_COUNT];
    logic [31:0] data_d [DATA_COUNT];
`ifdef DM_PROGBUF_EN
    logic [31:0] pb_q [PROGBUF_SIZE];
    logic [31:0] pb_d [PROGBUF_SIZE];
`endif

    logic        accept, busy, sel_data, sel_pb;
    logic [31:0] rd_data, dmstatus, abstractcs;

    assign req_rdy    = (dmi_state_q == D_IDLE);
    assign resp_vld   = (dmi_state_q == D_RESP);
    assign accept     = req_vld && req_rdy;
    assign busy       = (cmd_state_q != C_IDLE);
    assign cmd_vld    = (cmd_state_q == C_ISSUE);
    assign resp_addr  = resp_addr_q;
    assign resp_data  = resp_data_q;
    assign resp_op    = resp_op_q;
    assign haltreq    = haltreq_q;
    assign resumereq  = resumereq_q;
    assign ndmreset   = ndmreset_q;
    assign dmactive   = dmactive_q;
    assign cmd_word   = cmd_word_q;
    assign dbg_state  = {dmi_state_q, cmd_state_q};

    assign dmstatus   = {14'b0, {2{resumeack_q}}, 4'b0, {2{~hart_halted}}, {2{hart_halted}},
                         1'b1, 3'b0, 4'd2};
    assign abstractcs = {3'b0, PB_FIELD, 11'b0, busy, 1'b0, cmderr_q, 4'b0, 4'(DATA_COUNT)};

    always_comb begin
        dmi_state_d = dmi_state_q;
        cmd_state_d = cmd_state_q;
        resp_addr_d = resp_addr_q;
        resp_data_d = resp_data_q;
        resp_op_d   = resp_op_q;
        haltreq_d   = haltreq_q;
        resumereq_d = resumereq_q;
        ndmreset_d  = ndmreset_q;
        dmactive_d  = dmactive_q;
        resumeack_d = resumeack_q;
        cmderr_d    = cmderr_q;
        cmd_word_d  = cmd_word_q;
        data_d      = data_q;
        sel_data    = 1'b0;
        sel_pb      = 1'b0;
        rd_data     = '0;
`ifdef DM_PROGBUF_EN
        pb_d        = pb_q;
`endif

        case (req_addr)
            A_DMCONTROL: rd_data = {haltreq_q, 1'b0, 28'b0, ndmreset_q, dmactive_q};
            A_DMSTATUS:  rd_data = dmstatus;
            A_ABSCS:     rd_data = abstractcs;
            A_COMMAND:   rd_data = cmd_word_q;
            default:     rd_data = '0;
        endcase
        for (int i = 0; i < DATA_COUNT; i++) begin
            if (req_addr == 7'(4 + i)) begin
                sel_data = 1'b1;
                rd_data  = data_q[i];
            end
        end
`ifdef DM_PROGBUF_EN
        for (int i = 0; i < PROGBUF_SIZE; i++) begin
            if (req_addr == 7'(32 + i)) begin
                sel_pb  = 1'b1;
                rd_data = pb_q[i];
            end
        end
`endif

        case (cmd_state_q)
            C_ISSUE: if (cmd_rdy)  cmd_state_d = C_BUSY;
            C_BUSY:  if (cmd_done) cmd_state_d = C_IDLE;
            default: cmd_state_d = C_IDLE;
        endcase

        if (hart_resumeack) begin
            resumereq_d = 1'b0;
            resumeack_d = 1'b1;
        end

        case (dmi_state_q)
            D_IDLE: begin
                if (accept) begin
                    dmi_state_d = D_RESP;
                    resp_addr_d = req_addr;
                    resp_data_d = (req_op == 2'd1) ? rd_data : 32'h0;
                    resp_op_d   = (req_op == 2'd3) ? 2'd2 : 2'd0;
                end
            end
            D_RESP: if (resp_rdy) dmi_state_d = D_IDLE;
            default: dmi_state_d = D_IDLE;
        endcase

        if (accept && req_op == 2'd2) begin
            if (req_addr == A_DMCONTROL) begin
                dmactive_d = req_data[0];
                if (dmactive_q) begin
                    haltreq_d  = req_data[31];
                    ndmreset_d = req_data[1];
                    // haltreq takes priority over a simultaneous resume request
                    if (req_data[30] && !req_data[31]) begin
                        resumereq_d = 1'b1;
                        resumeack_d = 1'b0;
                    end
                end
            end else if (busy && (req_addr == A_COMMAND || req_addr == A_ABSCS || sel_data || sel_pb)) begin
                if (cmderr_q == 3'd0) cmderr_d = 3'd1;
            end else if (req_addr == A_COMMAND) begin
                if (cmderr_q == 3'd0) begin
                    cmd_word_d  = req_data;
                    cmd_state_d = C_ISSUE;
                end
            end else if (req_addr == A_ABSCS) begin
                cmderr_d = cmderr_q & ~req_data[10:8];
            end else begin
                for (int i = 0; i < DATA_COUNT; i++)
                    if (req_addr == 7'(4 + i)) data_d[i] = req_data;
`ifdef DM_PROGBUF_EN
                for (int i = 0; i < PROGBUF_SIZE; i++)
                    if (req_addr == 7'(32 + i)) pb_d[i] = req_data;
`endif
            end
        end

        if (cmd_state_q == C_BUSY && cmd_done && cmd_err != 3'd0 && cmderr_d == 3'd0)
            cmderr_d = cmd_err;

        // Applied after the DMI write so the hart wins a same-register collision
        for (int i = 0; i < DATA_COUNT; i++)
            if (hart_data_we && hart_data_idx == 4'(i)) data_d[i] = hart_data_wdata;

        if (!dmactive_d) begin
            haltreq_d   = 1'b0;
            resumereq_d = 1'b0;
            ndmreset_d  = 1'b0;
            resumeack_d = 1'b0;
            cmderr_d    = 3'd0;
            cmd_word_d  = '0;
            cmd_state_d = C_IDLE;
            for (int i = 0; i < DATA_COUNT; i++) data_d[i] = '0;
`ifdef DM_PROGBUF_EN
            for (int i = 0; i < PROGBUF_SIZE; i++) pb_d[i] = '0;
`endif
        end
    end

    always_ff @(posedge clk2 or posedge rst_ck2) begin
        if (rst_ck2) begin
            dmi_state_q <= D_IDLE;
            cmd_state_q <= C_IDLE;
            resp_addr_q <= '0;
            resp_data_q <= '0;
            resp_op_q   <= '0;
            haltreq_q   <= 1'b0;
            resumereq_q <= 1'b0;
            ndmreset_q  <= 1'b0;
            dmactive_q  <= 1'b0;
            resumeack_q <= 1'b0;
            cmderr_q    <= '0;
            cmd_word_q  <= '0;
            for (int i = 0; i < DATA_COUNT; i++) data_q[i] <= '0;
`ifdef DM_PROGBUF_EN
            for (int i = 0; i < PROGBUF_SIZE; i++) pb_q[i] <= '0;
`endif
        end else begin
            dmi_state_q <= dmi_state_d;
            cmd_state_q <= cmd_state_d;
            resp_addr_q <= resp_addr_d;
            resp_data_q <= resp_data_d;
            resp_op_q   <= resp_op_d;
            haltreq_q   <= haltreq_d;
            resumereq_q <= resumereq_d;
            ndmreset_q  <= ndmreset_d;
            dmactive_q  <= dmactive_d;
            resumeack_q <= resumeack_d;
            cmderr_q    <= cmderr_d;
            cmd_word_q  <= cmd_word_d;
            data_q      <= data_d;
`ifdef DM_PROGBUF_EN
            pb_q        <= pb_d;
`endif
        end
    end
endmodule

// File: tb/tb_dm_dmi_regfile.sv
// Bench for dm_dmi_regfile: directed scenarios plus randomized traffic against a register-level model.
module tb_dm_dmi_regfile;
  localparam int DC = 2;
  localparam int PB = 2;
`ifdef DM_PROGBUF_EN
  localparam bit PB_EN = 1'b1;
`else
  localparam bit PB_EN = 1'b0;
`endif

  logic        clk2 = 1'b0;
  logic        rst_ck2 = 1'b1;
  logic        req_vld = 1'b0, req_rdy;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_op = '0;
  logic        resp_vld, resp_rdy = 1'b1;
  logic [6:0]  resp_addr;
  logic [31:0] resp_data;
  logic [1:0]  resp_op;
  logic        haltreq, resumereq, ndmreset, dmactive;
  logic        hart_halted = 1'b0, hart_resumeack = 1'b0;
  logic        cmd_vld, cmd_rdy = 1'b0;
  logic [31:0] cmd_word;
  logic        cmd_done = 1'b0;
  logic [2:0]  cmd_err = '0;
  logic        hart_data_we = 1'b0;
  logic [3:0]  hart_data_idx = '0;
  logic [31:0] hart_data_wdata = '0;
  logic [2:0]  dbg_state;

  dm_dmi_regfile #(.DATA_COUNT(DC), .PROGBUF_SIZE(PB)) dut (
    .clk2(clk2), .rst_ck2(rst_ck2),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_data(req_data), .req_op(req_op),
    .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_addr(resp_addr), .resp_data(resp_data), .resp_op(resp_op),
    .haltreq(haltreq), .resumereq(resumereq), .ndmreset(ndmreset), .dmactive(dmactive),
    .hart_halted(hart_halted), .hart_resumeack(hart_resumeack),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_word(cmd_word), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .hart_data_we(hart_data_we), .hart_data_idx(hart_data_idx), .hart_data_wdata(hart_data_wdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk2 = ~clk2;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard and reference model state
  int n_tests = 0;
  int n_fail = 0;
  logic [40:0] exp_q[$];
  bit m_in_resp, m_last_acc;
  bit m_dmactive, m_haltreq, m_ndmreset, m_resumereq, m_ack;
  bit m_busy, m_issuing;
  logic [2:0]  m_cmderr;
  logic [31:0] m_cmd_word;
  logic [31:0] m_data [DC];
  logic [31:0] m_pb [PB];
  logic [6:0]  addr_tab [12] = '{7'h04, 7'h05, 7'h06, 7'h10, 7'h11, 7'h16,
                                 7'h17, 7'h17, 7'h20, 7'h21, 7'h00, 7'h3F};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear_regs();
    m_haltreq = 0; m_ndmreset = 0; m_resumereq = 0; m_ack = 0;
    m_busy = 0; m_issuing = 0; m_cmderr = '0; m_cmd_word = '0;
    for (int i = 0; i < DC; i++) m_data[i] = '0;
    for (int i = 0; i < PB; i++) m_pb[i] = '0;
  endtask

  task automatic model_reset_all();
    model_clear_regs();
    m_dmactive = 0; m_in_resp = 0; m_last_acc = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [6:0] addr);
    int a = int'(addr);
    logic [31:0] v = 32'h0;
    if (a == 'h10) v = (m_haltreq ? 32'h8000_0000 : 0) + (m_ndmreset ? 2 : 0) + (m_dmactive ? 1 : 0);
    else if (a == 'h11) v = 2 + 128 + (hart_halted ? 'h300 : 'hC00) + (m_ack ? 'h30000 : 0);
    else if (a == 'h16) v = ((PB_EN ? PB : 0) << 24) + (m_busy ? 'h1000 : 0) + (int'(m_cmderr) << 8) + DC;
    else if (a == 'h17) v = m_cmd_word;
    else if (a >= 4 && a < 4 + DC) v = m_data[a - 4];
    else if (PB_EN && a >= 32 && a < 32 + PB) v = m_pb[a - 32];
    return v;
  endfunction

  // Effect of the next rising edge, computed from the inputs currently driven.
  task automatic model_edge();
    bit acc, was_busy, was_exec, was_active, is_data, is_pb;
    int a;
    logic [31:0] d;
    acc = req_vld && !m_in_resp;
    was_busy = m_busy;
    was_exec = m_busy && !m_issuing;
    was_active = m_dmactive;
    a = int'(req_addr);
    d = req_data;
    is_data = (a >= 4 && a < 4 + DC);
    is_pb = PB_EN && (a >= 32 && a < 32 + PB);
    m_last_acc = acc;
    if (acc) begin
      exp_q.push_back({req_addr, (req_op == 2'd1) ? model_read(req_addr) : 32'h0,
                       (req_op == 2'd3) ? 2'd2 : 2'd0});
      m_in_resp = 1;
    end else if (m_in_resp && resp_rdy) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_in_resp = 0;
    end
    if (m_issuing && cmd_rdy) m_issuing = 0;
    else if (was_exec && cmd_done) m_busy = 0;
    if (hart_resumeack) begin m_resumereq = 0; m_ack = 1; end
    if (acc && req_op == 2'd2) begin
      if (a == 'h10) begin
        m_dmactive = d[0];
        if (was_active) begin
          m_haltreq = d[31];
          m_ndmreset = d[1];
          if (d[30] && !d[31]) begin m_resumereq = 1; m_ack = 0; end
        end
      end else if (was_busy && (a == 'h16 || a == 'h17 || is_data || is_pb)) begin
        if (m_cmderr == 0) m_cmderr = 3'd1;
      end else if (a == 'h17) begin
        if (m_cmderr == 0) begin m_cmd_word = d; m_busy = 1; m_issuing = 1; end
      end else if (a == 'h16) m_cmderr = m_cmderr & ~d[10:8];
      else if (is_data) m_data[a - 4] = d;
      else if (is_pb) m_pb[a - 32] = d;
    end
    if (was_exec && cmd_done && cmd_err != 0 && m_cmderr == 0) m_cmderr = cmd_err;
    if (hart_data_we && int'(hart_data_idx) < DC) m_data[int'(hart_data_idx)] = hart_data_wdata;
    if (!m_dmactive) model_clear_regs();
  endtask

  task automatic check_outputs();
    check_val("req_rdy", req_rdy, !m_in_resp);
    check_val("resp_vld", resp_vld, m_in_resp);
    if (m_in_resp) begin
      if (exp_q.size() == 0) check_val("resp_q_size", exp_q.size(), 1);
      else check_val("resp", {resp_addr, resp_data, resp_op}, exp_q[0]);
    end
    check_val("cmd_vld", cmd_vld, m_issuing);
    check_val("cmd_word", cmd_word, m_cmd_word);
    check_val("hart_ctl", {haltreq, resumereq, ndmreset, dmactive},
              {m_haltreq, m_resumereq, m_ndmreset, m_dmactive});
  endtask

  // driver tasks: called at a negedge with inputs set, return at the next negedge
  task automatic tick();
    model_edge();
    @(posedge clk2);
    @(negedge clk2);
    check_outputs();
  endtask

  task automatic dmi(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    int guard = 0;
    req_vld = 1; req_op = op; req_addr = addr; req_data = wd; resp_rdy = 1;
    while (m_in_resp && guard < 20) begin tick(); guard++; end
    tick();
    req_vld = 0;
    check_val("accept_latency", resp_vld, 1'b1);
    rd = resp_data;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    model_reset_all();
    repeat (3) @(negedge clk2);
    check_val("rst_req_rdy", req_rdy, 1'b1);
    check_val("rst_outs", {resp_vld, resp_addr, resp_data, resp_op, haltreq, resumereq, ndmreset,
                           dmactive, cmd_vld, cmd_word}, 0);
    rst_ck2 = 0;
    @(negedge clk2);

    dmi(2'd1, 7'h11, 32'h0, rd);
    check_val("dmstatus_reset", rd, 32'h0000_0C82);
    check_val("dmstatus_op", resp_op, 2'd0);

    dmi(2'd2, 7'h10, 32'h1, rd);
    dmi(2'd2, 7'h04, 32'hDEAD_BEEF, rd);
    dmi(2'd1, 7'h04, 32'h0, rd);
    check_val("data0_rw", rd, 32'hDEAD_BEEF);
    dmi(2'd2, 7'h10, 32'h0, rd);
    dmi(2'd2, 7'h04, 32'h1234_5678, rd);
    dmi(2'd1, 7'h04, 32'h0, rd);
    check_val("data0_inactive", rd, 32'h0);
    dmi(2'd2, 7'h10, 32'h1, rd);

    dmi(2'd2, 7'h17, 32'h0022_1000, rd);
    check_val("cmd_vld_issue", cmd_vld, 1'b1);
    check_val("cmd_word_issue", cmd_word, 32'h0022_1000);
    cmd_rdy = 0;
    repeat (3) tick();
    dmi(2'd1, 7'h16, 32'h0, rd);
    check_val("abscs_busy", rd[12], 1'b1);
    dmi(2'd2, 7'h17, 32'h0022_1000, rd);
    dmi(2'd1, 7'h16, 32'h0, rd);
    check_val("cmderr_busy_write", rd[10:8], 3'd1);
    cmd_rdy = 1; tick(); cmd_rdy = 0;
    check_val("cmd_vld_taken", cmd_vld, 1'b0);
    cmd_done = 1; tick(); cmd_done = 0;
    dmi(2'd2, 7'h16, 32'h0000_0700, rd);
    dmi(2'd1, 7'h16, 32'h0, rd);
    check_val("cmderr_w1c", rd[10:8], 3'd0);
    check_val("abscs_idle", rd[12], 1'b0);

    dmi(2'd2, 7'h17, 32'h0022_1001, rd);
    cmd_rdy = 1; tick(); cmd_rdy = 0;
    cmd_done = 1; cmd_err = 3'd3; tick(); cmd_done = 0; cmd_err = 3'd0;
    dmi(2'd1, 7'h16, 32'h0, rd);
    check_val("cmderr_exec", rd[10:8], 3'd3);
    dmi(2'd2, 7'h17, 32'h0022_1002, rd);
    check_val("cmd_blocked", cmd_vld, 1'b0);
    dmi(2'd2, 7'h16, 32'h0000_0700, rd);

    dmi(2'd2, 7'h10, 32'h4000_0001, rd);
    check_val("resumereq_set", resumereq, 1'b1);
    hart_resumeack = 1; tick(); hart_resumeack = 0;
    check_val("resumereq_clr", resumereq, 1'b0);
    dmi(2'd1, 7'h11, 32'h0, rd);
    check_val("dmstatus_ack", rd[17:16], 2'b11);
    dmi(2'd2, 7'h10, 32'hC000_0001, rd);
    check_val("halt_over_resume", {haltreq, resumereq}, 2'b10);
    dmi(2'd2, 7'h10, 32'h1, rd);

    hart_data_we = 1; hart_data_idx = 4'd1; hart_data_wdata = 32'hA5A5_0001;
    dmi(2'd2, 7'h05, 32'h5A5A_0002, rd);
    hart_data_we = 0;
    dmi(2'd1, 7'h05, 32'h0, rd);
    check_val("hart_wins", rd, 32'hA5A5_0001);

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!req_vld || m_last_acc) begin
        int k = $urandom_range(0, 9);
        req_vld = ($urandom_range(0, 2) != 0);
        req_addr = addr_tab[$urandom_range(0, 11)];
        req_op = (k == 0) ? 2'd0 : (k < 5) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
        req_data = $urandom;
        if (req_addr == 7'h10) req_data[0] = ($urandom_range(0, 9) != 0);
        if (req_addr == 7'h16 && $urandom_range(0, 1) == 1) req_data = 32'h0000_0700;
      end
      resp_rdy = ($urandom_range(0, 3) != 0);
      cmd_rdy = $urandom_range(0, 1);
      cmd_done = m_busy && !m_issuing && ($urandom_range(0, 3) == 0);
      cmd_err = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      hart_data_we = ($urandom_range(0, 3) == 0);
      hart_data_idx = 4'($urandom_range(0, 3));
      hart_data_wdata = $urandom;
      hart_resumeack = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) hart_halted = ~hart_halted;
      tick();
    end
    req_vld = 0; resp_rdy = 1; cmd_done = 0; cmd_rdy = 0; hart_data_we = 0; hart_resumeack = 0;
    for (int i = 0; i < 4 && m_in_resp; i++) tick();

    // reserved op, stalled response, reset during RESP
    req_vld = 1; req_op = 2'd3; req_addr = 7'h2A; req_data = $urandom; resp_rdy = 0;
    for (int i = 0; i < 4 && m_in_resp; i++) tick();
    tick();
    req_vld = 0;
    check_val("reserved_op", resp_op, 2'd2);
    repeat (5) begin
      tick();
      check_val("resp_stable", {resp_addr, resp_data, resp_op}, {7'h2A, 32'h0, 2'd2});
      check_val("req_rdy_stall", req_rdy, 1'b0);
    end
    rst_ck2 = 1;
    #1;
    check_val("rst_resp_vld", resp_vld, 1'b0);
    check_val("rst_req_rdy_now", req_rdy, 1'b1);
    model_reset_all();
    @(negedge clk2);
    rst_ck2 = 0;
    resp_rdy = 1;
    @(negedge clk2);
    dmi(2'd1, 7'h04, 32'h0, rd);
    check_val("data_after_reset", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
